// File: rtl/cu_seq.sv
// cu_seq: parametrised microcode sequencer for the jrb8 core.
// Latches an opcode, then walks PHASES microcode words addressed as
// {phase, ir}, driving control flags, the program counter, a write strobe
// and a start/done handshake with the multi-cycle ALU. Supports early
// end-of-instruction and a resumable halt.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ir_in         opcode from the memory bus (latched in FETCH)
//   ucode_addr    {ph, ir} microcode address (from registers)
//   ucode_data    microcode word for ucode_addr (async ROM, same cycle)
//   flags         active control flags
//   alu_start     one-cycle ALU launch pulse
//   alu_done      ALU result valid (level or pulse), only seen in ALU_WAIT
//   pc_load/pc_in jump request and target, applied in EVENTS
//   pc, ir        program counter and latched opcode
//   write_en      register/memory write strobe (EVENTS)
//   resume        leave HALTED into EVENTS of the halting phase
//   halted        sequencer is halted
module cu_seq #(
  parameter int unsigned          IR_W        = 10,
  parameter int unsigned          PC_W        = 23,
  parameter int unsigned          FLAGS_LEN   = 27,
  parameter int unsigned          PHASES      = 2,
  parameter int unsigned          PCC_BIT     = 0,
  parameter int unsigned          ALUO_BIT    = 1,
  parameter int unsigned          HALT_BIT    = 2,
  parameter int unsigned          EOI_BIT     = 3,
  parameter logic [FLAGS_LEN-1:0] FETCH_FLAGS = '0,
  parameter logic [PC_W-1:0]      PC_RESET    = '0,
  localparam int unsigned         PH_W        = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IR_W-1:0]      ir_in,
  output logic [PH_W+IR_W-1:0] ucode_addr,
  input  logic [FLAGS_LEN-1:0] ucode_data,
  output logic [FLAGS_LEN-1:0] flags,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic                 pc_load,
  input  logic [PC_W-1:0]      pc_in,
  output logic [PC_W-1:0]      pc,
  output logic [IR_W-1:0]      ir,
  output logic                 write_en,
  input  logic                 resume,
  output logic                 halted
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_ALU_WAIT,
    ST_EVENTS,
    ST_HALTED
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph;

  // alu_start, write_en and halted are registered: each is set on the
  // transition into the state that owns it, so they line up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      ph        <= '0;
      pc        <= PC_RESET;
      ir        <= '0;
      alu_start <= 1'b0;
      write_en  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      write_en  <= 1'b0;
      halted    <= 1'b0;
      case (state)
        ST_FETCH: begin
          ir    <= ir_in;
          pc    <= pc + PC_W'(1);
          ph    <= '0;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ucode_data[HALT_BIT]) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            if (ucode_data[PCC_BIT])
              pc <= pc + PC_W'(1);
            if (ucode_data[ALUO_BIT]) begin
              state     <= ST_ALU_WAIT;
              alu_start <= 1'b1;
            end else begin
              state    <= ST_EVENTS;
              write_en <= 1'b1;
            end
          end
        end
        ST_ALU_WAIT: begin
          if (alu_done) begin
            state    <= ST_EVENTS;
            write_en <= 1'b1;
          end
        end
        ST_EVENTS: begin
          if (pc_load)
            pc <= pc_in;
          if (ph == PH_LAST || ucode_data[EOI_BIT]) begin
            state <= ST_FETCH;
          end else begin
            ph    <= ph + PH_W'(1);
            state <= ST_EXEC;
          end
        end
        ST_HALTED: begin
          // ph is untouched, so EVENTS completes the phase that halted
          if (resume) begin
            state    <= ST_EVENTS;
            write_en <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    flags = ucode_data;
    case (state)
      ST_FETCH:  flags = FETCH_FLAGS;
      ST_HALTED: flags = '0;
      default:   flags = ucode_data;
    endcase
  end

  assign ucode_addr = {ph, ir};

endmodule
